muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M/RV64M multiply/divide unit, parametrised in XLEN, attached beside the ALU.
//  Accepts one M-extension op with operands from the register file, stalls the pipeline via
//  busy, and returns one XLEN result with a one-cycle done pulse.
//  The controller muxes result onto the writeback path when done=1.
// PARAMETERS
//  XLEN     32  operand/result width; 32 or 64
//  CNT_W    6   iteration counter width; must satisfy 2**CNT_W > XLEN
// PORTS
//  clk      in   1     rising-edge clock, single domain
//  reset    in   1     asynchronous, active-high reset
//  start    in   1     request; sampled only in IDLE or DONE
//  op       in   3     funct3: 0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//  a        in   XLEN  rs1 operand, sampled with start
//  b        in   XLEN  rs2 operand, sampled with start
//  flush    in   1     synchronous abort (branch/trap kill)
//  busy     out  1     operation in progress; the datapath holds the PC while 1
//  done     out  1     one-cycle pulse; result valid
//  result   out  XLEN  registered result; held until the next accepted start
// BEHAVIOUR
//  - States: IDLE, CALC, DONE. Async reset: state=IDLE, counter=0; busy, done, result and all
//    internal registers are 0.
//  - IDLE/DONE accept start:
//    - latch op, a and b, plus operand magnitudes and sign flags;
//    - go to CALC with counter=XLEN-1.
//  - IDLE/DONE with no start: go to IDLE. DONE therefore lasts exactly one cycle.
//  - CALC: one iteration per cycle; at counter==0 go to DONE, else decrement.
//    - busy=1 only in CALC; done=1 only in DONE.
//  - Latency: start sampled at edge N -> busy during cycles N+1..N+XLEN -> done at cycle N+XLEN+1.
//    Back-to-back ops are allowed: a start during DONE is accepted.
//  - start while in CALC is ignored. Operands and op are not re-sampled.
//  - Fast path (div ops only), decided at accept. Go directly IDLE->DONE; done at cycle N+1;
//    busy stays 0.
//    - b==0: DIV/DIVU quotient = all ones; REM/REMU = a.
//    - Signed overflow, a==1<<(XLEN-1) and b==all ones: DIV = a; REM = 0.
//  - Multiply: shift-add on the 2*XLEN accumulator, using magnitudes.
//    - Magnitudes: MUL/MULH negate both negative operands. MULHSU negates only a.
//      MULHU uses no sign handling.
//    - Negate the 2*XLEN product if exactly one operand was treated as negative.
//    - MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN].
//  - Divide: restoring, one quotient bit per cycle on magnitudes (signed ops negate negatives).
//    - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
//    - DIVU/REMU are fully unsigned.
//  - Sign correction and output select happen on the CALC->DONE transition; result registers there.
//  - result changes only on entry to DONE; otherwise it holds its last value.
//  - flush=1 in any state: next state IDLE, no done pulse, result unchanged.
//    - flush has priority over start in the same cycle.
//    - Asserting flush in DONE does not retract the done pulse of that cycle.
//  - Reset mid-operation: outputs are 0 immediately (asynchronous). The first accepted start
//    after reset deassertion proceeds normally.
//  - All arithmetic wraps modulo 2**XLEN (2**(2*XLEN) internally); no exceptions are raised.
// TESTING (XLEN=32)
//  - MUL a=7 b=0xFFFFFFFD, start at cycle 0 -> busy in cycles 1..32; done at cycle 33 with
//    result 0xFFFFFFEB.
//  - a=b=0xFFFFFFFF:
//    - MULHU -> 0xFFFFFFFE;
//    - MULH -> 0x00000000;
//    - MULHSU -> 0xFFFFFFFF;
//    - MUL -> 0x00000001.
//  - a=0xFFFFFFF9 (-7), b=2: DIV -> 0xFFFFFFFD; REM -> 0xFFFFFFFF. a=7, b=2, DIVU -> 3.
//  - Fast paths: REMU a=5 b=0 -> 5 at cycle 1 with busy never 1; DIVU b=0 -> 0xFFFFFFFF;
//    DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
//  - Abort and ignore:
//    - MUL started; flush at cycle 10 -> busy=0 from cycle 11; no done; result keeps its old value.
//    - start with new operands at cycle 5 of a CALC -> ignored.
//    - Start during DONE -> second result is done exactly 33 cycles later.
//  - Assert reset asynchronously at cycle 12 of a DIV -> busy, done and result are 0 before the
//    next clock edge; after release, MUL 3*4 -> 12 at latency 33.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with single-cycle fast paths for divide-by-zero and signed overflow.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [2:0]          op_q;
    logic                neg_a_q, neg_b_q;
    logic [XLEN-1:0]     opb_q;
    logic [2*XLEN-1:0]   acc;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic s);
        return s ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v, input logic s);
        return s ? -v : v;
    endfunction

    logic            accept, fast_zero, fast_ovf, fast;
    logic            neg_a_in, neg_b_in;
    logic [XLEN-1:0] mag_a, mag_b, fast_res;

    assign accept    = (state != CALC) && start && !flush;
    assign fast_zero = op[2] && (b == '0);
    assign fast_ovf  = op[2] && !op[0] && (a == MOST_NEG) && (b == '1);
    assign fast      = fast_zero || fast_ovf;
    assign fast_res  = fast_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);

    // Which operands are treated as two's-complement depends on the op.
    always_comb begin
        neg_a_in = 1'b0;
        neg_b_in = 1'b0;
        case (op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                neg_a_in = a[XLEN-1];
                neg_b_in = b[XLEN-1];
            end
            OP_MULHSU: neg_a_in = a[XLEN-1];
            default: ;
        endcase
    end

    assign mag_a = cond_neg(a, neg_a_in);
    assign mag_b = cond_neg(b, neg_b_in);

    // acc holds {partial product, multiplier} for multiply, {remainder, dividend/quotient} for divide.
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic              q_bit;
    logic [2*XLEN-1:0] mul_nxt, div_nxt, acc_nxt, prod;
    logic [XLEN-1:0]   quo, rem, calc_res;

    assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb_q} : '0);
    assign mul_nxt   = {mul_sum, acc[XLEN-1:1]};
    assign div_shift = acc[2*XLEN-1:XLEN-1];
    assign div_diff  = div_shift - {1'b0, opb_q};
    assign q_bit     = !div_diff[XLEN];
    assign div_nxt   = {(q_bit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc[XLEN-2:0], q_bit};
    assign acc_nxt   = op_q[2] ? div_nxt : mul_nxt;

    assign prod = cond_neg2(acc_nxt, neg_a_q ^ neg_b_q);
    assign quo  = cond_neg(acc_nxt[XLEN-1:0], neg_a_q ^ neg_b_q);
    assign rem  = cond_neg(acc_nxt[2*XLEN-1:XLEN], neg_a_q);

    always_comb begin
        calc_res = '0;
        case (op_q)
            OP_MUL:                       calc_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: calc_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              calc_res = quo;
            OP_REM, OP_REMU:              calc_res = rem;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: state_nxt = start ? (fast ? DONE : CALC) : IDLE;
                CALC:       state_nxt = (cnt == '0) ? DONE : CALC;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            op_q    <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            opb_q   <= '0;
            acc     <= '0;
            result  <= '0;
        end else if (accept) begin
            cnt     <= CNT_W'(XLEN - 1);
            op_q    <= op;
            neg_a_q <= neg_a_in;
            neg_b_q <= neg_b_in;
            opb_q   <= mag_b;
            acc     <= {{XLEN{1'b0}}, mag_a};
            if (fast) result <= fast_res;
        end else if (state == CALC && !flush) begin
            acc <= acc_nxt;
            if (cnt == '0) result <= calc_res;
            else           cnt    <= cnt - 1'b1;
        end
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (XLEN=32): vector table plus hand-written flush,
// ignore, back-to-back and asynchronous-reset sequences.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  op;
    logic [31:0] a, b, result;
    logic        busy, done;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .result(result)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output logic [31:0] res, output int lat, output int nbusy);
        lat = 0; nbusy = 0; res = 'x;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (busy) nbusy++;
            if (done) begin
                res = result;
                return;
            end
        end
        lat = -1;
    endtask

    logic [31:0] r;
    int          lat, nb, ndone;

    initial begin
        vecs[0]  = '{3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 33};
        vecs[1]  = '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        vecs[2]  = '{3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 33};
        vecs[3]  = '{3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 33};
        vecs[4]  = '{3'd0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000001, 33};
        vecs[5]  = '{3'd4, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 33};
        vecs[6]  = '{3'd6, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 33};
        vecs[7]  = '{3'd5, 32'd7,          32'd2,        32'd3,        33};
        vecs[8]  = '{3'd7, 32'd5,          32'd0,        32'd5,        1};
        vecs[9]  = '{3'd5, 32'd123,        32'd0,        32'hFFFFFFFF, 1};
        vecs[10] = '{3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1};
        vecs[11] = '{3'd6, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 1};
        vecs[12] = '{3'd3, 32'h80000000,   32'd2,        32'h00000001, 33};
        vecs[13] = '{3'd4, 32'd100,        32'hFFFFFFF9, 32'hFFFFFFF2, 33};
        vecs[14] = '{3'd6, 32'd100,        32'hFFFFFFF9, 32'h00000002, 33};
        vecs[15] = '{3'd5, 32'hFFFFFFFF,   32'd10,       32'h19999999, 33};
        vecs[16] = '{3'd7, 32'hFFFFFFFF,   32'd10,       32'd5,        33};
        vecs[17] = '{3'd1, 32'h80000000,   32'h80000000, 32'h40000000, 33};
        vecs[18] = '{3'd2, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 33};

        reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(r, lat, nb);
            check($sformatf("vec%0d_result", i), r, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_busy_cycles", i), nb, (vecs[i].lat == 1) ? 0 : 32);
            @(negedge clk);
            check($sformatf("vec%0d_done_one_cycle", i), {31'd0, done}, 32'd0);
        end

        // Back-to-back: second start issued in the DONE cycle of the first.
        launch(3'd0, 32'd2, 32'd3);
        wait_done(r, lat, nb);
        check("b2b_first_result", r, 32'd6);
        start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(r, lat, nb);
        check("b2b_second_result", r, 32'd81);
        check("b2b_second_latency", lat, 33);

        // Flush at cycle 10 of a multiply.
        launch(3'd0, 32'd3, 32'd5);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy_low", {31'd0, busy}, 32'd0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("flush_no_done", ndone, 0);
        check("flush_result_held", result, 32'd81);

        // New start at cycle 5 of CALC must be ignored.
        launch(3'd0, 32'd6, 32'd7);
        repeat (5) @(negedge clk);
        start = 1'b1; op = 3'd5; a = 32'd100; b = 32'd0;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(r, lat, nb);
        check("ignore_result", r, 32'd42);
        check("ignore_latency", (lat < 0) ? -1 : lat + 5, 33);

        // Flush in DONE together with start: pulse stays, nothing accepted.
        launch(3'd5, 32'd9, 32'd0);
        @(negedge clk);
        check("donefl_done_pulse", {31'd0, done}, 32'd1);
        check("donefl_result", result, 32'hFFFFFFFF);
        flush = 1'b1; start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd2;
        @(posedge clk);
        #1 begin flush = 1'b0; start = 1'b0; end
        @(negedge clk);
        check("donefl_busy", {31'd0, busy}, 32'd0);
        check("donefl_done", {31'd0, done}, 32'd0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("donefl_no_done", ndone, 0);
        check("donefl_result_held", result, 32'hFFFFFFFF);

        // Asynchronous reset at cycle 12 of a divide.
        launch(3'd4, 32'd100, 32'd7);
        repeat (12) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("areset_busy", {31'd0, busy}, 32'd0);
        check("areset_done", {31'd0, done}, 32'd0);
        check("areset_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        launch(3'd0, 32'd3, 32'd4);
        wait_done(r, lat, nb);
        check("after_reset_result", r, 32'd12);
        check("after_reset_latency", lat, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
